ff_pipe_elastic: RTL

//   Parametrised successor to the single valid-qualified data register: a DEPTH-stage,
//   NUM_CH-lane elastic pipeline with valid/ready backpressure, synchronous flush and

---
 rtl/ff_pkg.sv | 13 +
 rtl/ff_pipe_elastic_if.sv | 11 +
 rtl/ff_pipe_stage.sv | 44 ++++
 rtl/ff_pipe_elastic.sv | 82 ++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared helpers for the elastic pipeline: counter width rule and lane slicing.
package ff_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Lane k of a packed multi-lane bus starts at this bit.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ff_pipe_elastic_if.sv
// One valid/ready beat channel; the pipeline uses one instance per side.
interface ff_pipe_elastic_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] data;
    logic             vld;
    logic             rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/ff_pipe_stage.sv
// One elastic register stage; the ready that gates it is supplied by the top.
module ff_pipe_stage #(
    parameter int WIDTH     = 64,
    parameter int HOLD_DATA = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             prev_vld,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] data
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Flush empties the stage without moving data; otherwise advance only when ready.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush) begin
            vld_d = 1'b0;
            if (HOLD_DATA == 0) data_d = '0;
        end else if (rdy) begin
            vld_d = prev_vld;
            if (prev_vld) data_d = prev_data;
            else if (HOLD_DATA == 0) data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign data = data_q;
endmodule

// File: rtl/ff_pipe_elastic.sv
// DEPTH-stage, NUM_CH-lane elastic pipeline with shared valid/ready, flush and occupancy.
module ff_pipe_elastic
    import ff_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 2,
    parameter  int DEPTH      = 3,
    parameter  int HOLD_DATA  = 1,
    localparam int W          = NUM_CH * DATA_WIDTH,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    ff_pipe_elastic_if.slave   up,
    ff_pipe_elastic_if.master  dn,
    output logic [CNT_W-1:0]   occupancy
);
    if (DEPTH < 1) begin : g_bad_depth
        $error("ff_pipe_elastic: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] stg_vld;
    logic [W-1:0]     stg_data [DEPTH];
    logic [DEPTH:0]   stg_rdy;

    assign stg_rdy[DEPTH] = dn.rdy;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic         prev_vld;
        logic [W-1:0] prev_data;

        if (i == 0) begin : g_head
            assign prev_vld  = up.vld;
            assign prev_data = up.data;
        end else begin : g_body
            assign prev_vld  = stg_vld[i-1];
            assign prev_data = stg_data[i-1];
        end

        // Unrolled ~vld[i] | ready[i+1]: a stage can move unless it and everything after it is full and stalled.
        assign stg_rdy[i] = dn.rdy | ~(&stg_vld[DEPTH-1:i]);

        ff_pipe_stage #(
            .WIDTH     (W),
            .HOLD_DATA (HOLD_DATA)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .prev_vld  (prev_vld),
            .prev_data (prev_data),
            .rdy       (stg_rdy[i]),
            .vld       (stg_vld[i]),
            .data      (stg_data[i])
        );
    end

    assign up.rdy  = stg_rdy[0] & ~flush;
    assign dn.vld  = stg_vld[DEPTH-1];
    assign dn.data = stg_data[DEPTH-1];

    logic             in_acc, out_acc;
    logic [CNT_W-1:0] occ_q, occ_d;

    assign in_acc  = up.vld & up.rdy;
    assign out_acc = dn.vld & dn.rdy;

    always_comb begin
        occ_d = occ_q;
        if (flush)                  occ_d = '0;
        else if (in_acc & ~out_acc) occ_d = occ_q + CNT_W'(1);
        else if (out_acc & ~in_acc) occ_d = occ_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign occupancy = occ_q;
endmodule
